// File: rtl/irq_sequencer.sv
// Multi-source interrupt sequencer: edge-latches up to eight lines, masks them,
// requests the lowest eligible source and tracks its service routine until RETIE.
module irq_sequencer #(
  parameter int          N_SRC     = 8,
  parameter logic [7:0]  MASK_PORT = 8'hE0,
  parameter logic [7:0]  PEND_PORT = 8'hE1,
  parameter logic [7:0]  STAT_PORT = 8'hE2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             i_flag,
  input  logic             int_ack,
  output logic             int_req,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  input  logic             io_strb,
  output logic [7:0]       rd_data,
  output logic             rd_hit
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_SVC_ENTER = 2'd2;
  localparam logic [1:0] ST_SVC       = 2'd3;

  logic [1:0]       state;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [2:0]       active_id;
  logic             active_valid;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] win_oh;
  logic [N_SRC-1:0] pend_clr;
  logic [2:0]       win_id;
  logic             mask_wr;
  logic             pend_wr;
  logic             ack_take;

  assign rise     = irq_in & ~irq_q;
  assign elig     = pending & mask;
  // Isolates the lowest set bit of elig (two's-complement trick).
  assign win_oh   = elig & (~elig + 1'b1);
  assign mask_wr  = io_strb && (port_id == MASK_PORT);
  assign pend_wr  = io_strb && (port_id == PEND_PORT);
  assign ack_take = (state == ST_REQ) && int_ack;
  assign pend_clr = (pend_wr  ? out_port[N_SRC-1:0] : '0)
                  | (ack_take ? win_oh              : '0);
  assign int_req  = (state == ST_REQ);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    win_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = 3'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      irq_q        <= '0;
      pending      <= '0;
      mask         <= '0;
      active_id    <= 3'd0;
      active_valid <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      // Set wins over clear: rise is ORed in after the clear.
      pending <= (pending & ~pend_clr) | rise;
      if (mask_wr) mask <= out_port[N_SRC-1:0];

      case (state)
        ST_IDLE: begin
          if (i_flag && (|elig)) state <= ST_REQ;
        end
        ST_REQ: begin
          if (int_ack) begin
            active_id    <= win_id;
            active_valid <= 1'b1;
            state        <= ST_SVC_ENTER;
          end else if (!i_flag || !(|elig)) begin
            state <= ST_IDLE;
          end
        end
        ST_SVC_ENTER: begin
          if (!i_flag) state <= ST_SVC;
        end
        default: begin
          if (i_flag) begin
            active_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    rd_hit  = 1'b0;
    if (port_id == MASK_PORT) begin
      rd_hit               = 1'b1;
      rd_data[N_SRC-1:0]   = mask;
    end else if (port_id == PEND_PORT) begin
      rd_hit               = 1'b1;
      rd_data[N_SRC-1:0]   = pending;
    end else if (port_id == STAT_PORT) begin
      rd_hit               = 1'b1;
      rd_data              = {active_valid, 2'b00, state, active_id};
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Testbench for irq_sequencer: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural reference model.
module tb_irq_sequencer;

  localparam logic [7:0] MASK_PORT = 8'hE0;
  localparam logic [7:0] PEND_PORT = 8'hE1;
  localparam logic [7:0] STAT_PORT = 8'hE2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       i_flag;
  logic       int_ack;
  logic       int_req;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       rd_hit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_sequencer #(
    .N_SRC(8), .MASK_PORT(MASK_PORT), .PEND_PORT(PEND_PORT), .STAT_PORT(STAT_PORT)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .i_flag(i_flag), .int_ack(int_ack),
    .int_req(int_req), .port_id(port_id), .out_port(out_port), .io_strb(io_strb),
    .rd_data(rd_data), .rd_hit(rd_hit)
  );

  // Reference model: request flag plus a service phase counter
  // (0 = not servicing, 1 = waiting for I to clear, 2 = waiting for RETIE).
  logic [7:0] m_irq_q = '0, m_pend = '0, m_mask = '0;
  bit         m_req = 0, m_av = 0;
  int         m_phase = 0;
  int         m_aid = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_stat();
    int code;
    code = m_req ? 1 : (m_phase == 1) ? 2 : (m_phase == 2) ? 3 : 0;
    return 8'((m_av ? 128 : 0) + code * 8 + m_aid);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] p);
    if (p == MASK_PORT) return m_mask;
    if (p == PEND_PORT) return m_pend;
    if (p == STAT_PORT) return m_stat();
    return 8'h00;
  endfunction

  task automatic model_step();
    logic [7:0] rise, elig, clr;
    int win;
    if (rst) begin
      m_irq_q = '0; m_pend = '0; m_mask = '0;
      m_req = 0; m_av = 0; m_phase = 0; m_aid = 0;
      return;
    end
    rise = irq_in & ~m_irq_q;
    elig = m_pend & m_mask;
    win  = -1;
    for (int i = 0; i < 8; i++) if (win < 0 && elig[i]) win = i;
    clr = (io_strb && port_id == PEND_PORT) ? out_port : 8'h00;
    if (m_req) begin
      if (int_ack) begin
        m_aid = (win < 0) ? 0 : win;
        m_av  = 1;
        if (win >= 0) clr[win] = 1'b1;
        m_req = 0;
        m_phase = 1;
      end else if (!i_flag || elig == 0) begin
        m_req = 0;
      end
    end else if (m_phase == 1) begin
      if (!i_flag) m_phase = 2;
    end else if (m_phase == 2) begin
      if (i_flag) begin m_phase = 0; m_av = 0; end
    end else if (i_flag && elig != 0) begin
      m_req = 1;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (io_strb && port_id == MASK_PORT) m_mask = out_port;
    m_irq_q = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("int_req", {7'b0, int_req}, {7'b0, m_req});
    check("rd_data", rd_data, m_read(port_id));
    check("rd_hit", {7'b0, rd_hit},
          {7'b0, (port_id == MASK_PORT || port_id == PEND_PORT || port_id == STAT_PORT)});
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; io_strb = 1'b1;
    tick();
    io_strb = 1'b0; port_id = STAT_PORT;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] p, input logic [7:0] exp);
    port_id = p;
    #1;
    check(tag, rd_data, exp);
    port_id = STAT_PORT;
    #1;
  endtask

  task automatic req_check(input string tag, input logic exp);
    check(tag, {7'b0, int_req}, {7'b0, exp});
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; i_flag = 1'b0; int_ack = 1'b0;
    port_id = STAT_PORT; out_port = '0; io_strb = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    req_check("reset_req", 1'b0);
    rd_check("reset_stat", STAT_PORT, 8'h00);
    rd_check("reset_mask", MASK_PORT, 8'h00);

    // Basic request: latency 2 cycles from edge, ack moves to SVC_ENTER.
    wr(MASK_PORT, 8'h01);
    i_flag = 1'b1; irq_in = 8'h01;
    tick(); req_check("lat_edge", 1'b0);
    irq_in = 8'h00;
    tick(); req_check("lat_req", 1'b1);
    ack();
    req_check("ack_drop", 1'b0);
    rd_check("ack_stat", STAT_PORT, 8'h90);
    i_flag = 1'b0; tick(); rd_check("svc_stat", STAT_PORT, 8'h98);
    i_flag = 1'b1; tick(); rd_check("retie_stat", STAT_PORT, 8'h00);

    // Priority: pending 0C serves 2 then 3.
    i_flag = 1'b0;
    wr(MASK_PORT, 8'hFF);
    irq_in = 8'h0C; tick(); irq_in = 8'h00; tick();
    rd_check("pend_0c", PEND_PORT, 8'h0C);
    i_flag = 1'b1; tick(); req_check("prio_req", 1'b1);
    ack();
    rd_check("prio_stat2", STAT_PORT, 8'h92);
    rd_check("prio_pend", PEND_PORT, 8'h08);
    i_flag = 1'b0; tick();
    i_flag = 1'b1; tick(); req_check("retie_idle", 1'b0);
    tick(); req_check("rereq", 1'b1);
    ack();
    rd_check("prio_stat3", STAT_PORT, 8'h93);
    rd_check("prio_pend0", PEND_PORT, 8'h00);
    i_flag = 1'b0; tick(); i_flag = 1'b1; tick();

    // Masked source, then unmask.
    i_flag = 1'b0;
    wr(MASK_PORT, 8'h00);
    irq_in = 8'h10; tick(); irq_in = 8'h00; tick();
    i_flag = 1'b1; tick(); tick();
    req_check("masked_noreq", 1'b0);
    rd_check("masked_pend", PEND_PORT, 8'h10);
    wr(MASK_PORT, 8'h10); req_check("unmask_m1", 1'b0);
    tick(); req_check("unmask_m2", 1'b1);
    ack(); rd_check("unmask_stat", STAT_PORT, 8'h94);
    i_flag = 1'b0; tick(); i_flag = 1'b1; tick();

    // Withdrawal: drop I in REQ.
    wr(MASK_PORT, 8'h01);
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
    req_check("wd_req", 1'b1);
    i_flag = 1'b0; tick();
    req_check("wd_drop", 1'b0);
    rd_check("wd_pend", PEND_PORT, 8'h01);
    wr(PEND_PORT, 8'h01);
    rd_check("wd_clr", PEND_PORT, 8'h00);

    // Set beats W1C in the same cycle.
    irq_in = 8'h02; wr(PEND_PORT, 8'h02); irq_in = 8'h00;
    rd_check("set_wins", PEND_PORT, 8'h02);
    wr(PEND_PORT, 8'h02);
    rd_check("w1c_clr", PEND_PORT, 8'h00);

    // Reset in SVC with pending 05.
    wr(MASK_PORT, 8'hFF);
    i_flag = 1'b1; irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
    ack();
    i_flag = 1'b0; tick();
    irq_in = 8'h05; tick(); irq_in = 8'h00; tick();
    rd_check("svc_pend", PEND_PORT, 8'h05);
    rd_check("svc_stat2", STAT_PORT, 8'h98);
    rst = 1'b1; tick(); rst = 1'b0;
    rd_check("rst_pend", PEND_PORT, 8'h00);
    rd_check("rst_mask", MASK_PORT, 8'h00);
    rd_check("rst_stat", STAT_PORT, 8'h00);
    req_check("rst_req", 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      irq_in   = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 5) == 0) i_flag = ~i_flag;
      int_ack  = ($urandom_range(0, 3) == 0);
      io_strb  = ($urandom_range(0, 7) == 0);
      out_port = 8'($urandom);
      case ($urandom_range(0, 3))
        0: port_id = MASK_PORT;
        1: port_id = PEND_PORT;
        2: port_id = STAT_PORT;
        default: port_id = 8'($urandom);
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Multi-source interrupt sequencer for the pipelined RAT CPU. It sits between external interrupt lines and the pipeline controller's single interrupt input. It latches edges on up to eight sources, applies a software mask, and picks the lowest-numbered eligible source. It raises a request to the pipeline controller and holds it until acknowledged, then tracks the service routine until the CPU re-enables interrupts. Mask, pending and active-source state are reachable by the CPU through the existing IN/OUT port bus (`port_id`, `out_port`, `io_strb`, `in_port`).

## Interface
Parameters:
- `N_SRC`, 8, number of interrupt sources (1..8); unused bits of 8-bit registers read 0.
- `MASK_PORT`, 8'hE0, port id of mask register (read/write).
- `PEND_PORT`, 8'hE1, port id of pending register (read; write-1-to-clear).
- `STAT_PORT`, 8'hE2, port id of status register (read-only).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `irq_in`  in  N_SRC  interrupt lines, synchronous to `clk`, level; a rising edge requests service.
- `i_flag`  in  1  CPU interrupt-enable flag (I_FLAG output).
- `int_ack`  in  1  one-cycle pulse from the pipeline controller when the interrupt slot is taken.
- `int_req`  out  1  interrupt request to the pipeline controller.
- `port_id`  in  8  CPU port id (execute stage).
- `out_port`  in  8  CPU write data.
- `io_strb`  in  1  CPU output strobe.
- `rd_data`  out  8  read data, ORed into the CPU `in_port` mux.
- `rd_hit`  out  1  `port_id` matches one of the three ports.

## Operation
- Edge detect: `irq_q` is a registered copy of `irq_in`. `rise = irq_in & ~irq_q`.
- Pending update each edge: `pending <= (pending & ~clr) | rise`.
  - `clr` = `out_port` when `io_strb && port_id==PEND_PORT`.
  - `clr` includes the winner bit on an accepted ack.
  - Set beats clear on the same bit in the same cycle.
- Mask: `mask <= out_port[N_SRC-1:0]` when `io_strb && port_id==MASK_PORT`.
- Eligibility: `elig = pending & mask`. The winner is the lowest set index of `elig`.
- State machine (Moore; `int_req` = state==REQ):
  - IDLE: go to REQ when `i_flag && |elig`.
  - REQ:
    - On `int_ack`: `active_id <= winner`, `active_valid <= 1`, clear `pending[winner]`, go to SVC_ENTER.
    - Else, if `!i_flag || !|elig` (request withdrawn), go to IDLE.
    - `int_ack` takes priority over withdrawal in the same cycle.
  - SVC_ENTER: wait for `i_flag==0` (the CPU clears I on entry), then go to SVC.
  - SVC: wait for `i_flag==1` (RETIE), then `active_valid <= 0` and go to IDLE.
  - `int_ack` outside REQ is ignored. No state or pending change results.
- Nesting is not supported. New edges during SVC only set pending bits; they are serviced after return.
- Reads (combinational):
  - MASK_PORT returns `mask`.
  - PEND_PORT returns `pending`.
  - STAT_PORT returns `{active_valid, 2'b0, state[1:0], active_id[2:0]}`, with state encoding IDLE=0, REQ=1, SVC_ENTER=2, SVC=3.
  - Any other port: `rd_data=0`, `rd_hit=0`.
- Reset: `irq_q=0`, `pending=0`, `mask=0`, `active_id=0`, `active_valid=0`, state IDLE, `int_req=0`. Reset mid-REQ or mid-SVC returns to IDLE the next edge. Edges present during reset are not captured.

## Timing
- Edge n: `irq_in[i]` is 1 and `irq_q[i]` is 0. `pending[i]` is 1 after edge n.
- With mask and `i_flag` set, `int_req` is 1 after edge n+1. Minimum request latency is 2 cycles.
- Mask write at edge m is visible in `elig` in cycle m+1.
- `int_req` stays high until the edge that samples `int_ack`, or until withdrawal. It drops one cycle after either.
- `active_id` and `active_valid` are valid from the cycle after the ack edge.
- `rd_data` has zero latency from `port_id`, so it is sampled by the writeback register in the same cycle as the IN instruction's execute.
- After RETIE, a still-pending eligible source re-raises `int_req` no earlier than 2 cycles after `i_flag` rises (SVC→IDLE→REQ).

## Test plan
- Reset, then mask=8'h01, `i_flag`=1, pulse `irq_in[0]`.
  - Required: `int_req` rises 2 cycles after the edge.
  - On `int_ack`: `int_req` 0 next cycle, STAT reads 8'h80|(2<<3)|0.
- Pending 8'h0C, mask 8'hFF, ack.
  - Required: `active_id`=2, pending becomes 8'h08.
  - After the `i_flag` 1→0→1 sequence, `int_req` reasserts and the second ack gives `active_id`=3.
- Pending 8'h10, mask 8'h00.
  - Required: no `int_req`.
  - Writing mask=8'h10 gives `int_req` two cycles after the write strobe.
- In REQ, drop `i_flag` before the ack.
  - Required: `int_req` 0 next cycle, pending unchanged at 8'h01.
- Same-cycle W1C 8'h02 to PEND_PORT and rising `irq_in[1]`.
  - Required: `pending[1]` stays 1.
  - A W1C of 8'h02 with no edge clears it.
- Assert `rst` while in SVC with pending 8'h05.
  - Required: next cycle pending=0, mask=0, STAT=8'h00, `int_req`=0.
